// File: rtl/game_pkg.sv
// Shared definitions for the counting-game turn controller: FSM states,
// game mode encodings and player indices.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_UP1 = 2'b00;
  localparam logic [1:0] MODE_UP2 = 2'b01;
  localparam logic [1:0] MODE_DN1 = 2'b10;
  localparam logic [1:0] MODE_DN2 = 2'b11;

  localparam logic PLAYER0 = 1'b0;
  localparam logic PLAYER1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the player that wins a tie.
// Purely combinational, the pointer register is kept by the parent.
module rr_arbiter2
  import game_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 2'b00;
    if (ptr == PLAYER0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/game_turn_arbiter.sv
// Shares one counting-game instance between two players: round-robin turn
// grant, one-cycle game load, result wait with timeout, scoring and match end.
module game_turn_arbiter
  import game_pkg::*;
#(
  parameter  int INPUT      = 4,
  parameter  int TARGET     = 15,
  parameter  int WIN_POINTS = 3,
  parameter  int TIMEOUT    = 64,
  localparam int SW         = $clog2(WIN_POINTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       p0_mode,
  input  logic [1:0]       p1_mode,
  input  logic [INPUT-1:0] p0_seed,
  input  logic [INPUT-1:0] p1_seed,
  input  logic             new_match,
  output logic [1:0]       grant,
  output logic [1:0]       game_ctrl,
  output logic [INPUT-1:0] game_seed,
  output logic             game_init,
  input  logic             game_winner,
  input  logic             game_loser,
  input  logic             game_over,
  output logic [SW-1:0]    score0,
  output logic [SW-1:0]    score1,
  output logic             busy,
  output logic             timeout,
  output logic             match_done,
  output logic             match_winner
);

  localparam int               CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    CNT_MAX   = CW'(TIMEOUT);
  localparam logic [SW-1:0]    SCORE_MAX = SW'(WIN_POINTS);
  localparam logic [INPUT-1:0] SEED_TGT  = INPUT'(TARGET);
  localparam logic [INPUT-1:0] SEED_TOP  = INPUT'(TARGET - 1);

  // Keep the game away from its degenerate start values: 0 and >= TARGET.
  function automatic logic [INPUT-1:0] clamp_seed(input logic [INPUT-1:0] s);
    if (s == '0)            return INPUT'(1);
    else if (s >= SEED_TGT) return SEED_TOP;
    else                    return s;
  endfunction

  state_t          state, next_state;
  logic            ptr;
  logic [1:0]      arb_grant;
  logic [CW-1:0]   cnt;
  logic            win_flag, over_flag;
  logic            busy_d, done_d;
  logic [SW-1:0]   cur_score, new_score, new_score0, new_score1;
  logic            ends_match;

  rr_arbiter2 u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  // Score outcome of the round currently in SCORE.
  always_comb begin
    cur_score = grant[1] ? score1 : score0;
    new_score = cur_score;
    if (win_flag && (cur_score != SCORE_MAX)) new_score = cur_score + SW'(1);
    new_score0 = grant[0] ? new_score : score0;
    new_score1 = grant[1] ? new_score : score1;
    ends_match = (win_flag && (new_score == SCORE_MAX)) || over_flag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (|req) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (game_winner || game_loser || game_over) next_state = ST_SCORE;
        else if (cnt == CNT_MAX)                    next_state = ST_IDLE;
      end
      ST_SCORE: next_state = ends_match ? ST_DONE : ST_IDLE;
      ST_DONE:  if (new_match) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode: init straight from LOAD, the rest staged for registering.
  always_comb begin
    game_init = (state == ST_LOAD);
    busy_d    = (next_state == ST_LOAD) || (next_state == ST_WAIT) ||
                (next_state == ST_SCORE);
    done_d    = (next_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= PLAYER0;
      grant        <= 2'b00;
      game_ctrl    <= 2'b00;
      game_seed    <= '0;
      cnt          <= '0;
      win_flag     <= 1'b0;
      over_flag    <= 1'b0;
      score0       <= '0;
      score1       <= '0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      match_done   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      busy       <= busy_d;
      match_done <= done_d;
      timeout    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= arb_grant;
            game_ctrl <= arb_grant[1] ? p1_mode : p0_mode;
            game_seed <= clamp_seed(arb_grant[1] ? p1_seed : p0_seed);
          end
        end
        ST_LOAD: begin
          cnt       <= '0;
          win_flag  <= 1'b0;
          over_flag <= 1'b0;
        end
        ST_WAIT: begin
          if (game_winner || game_loser || game_over) begin
            win_flag  <= game_winner;
            over_flag <= game_over;
          end else if (cnt == CNT_MAX) begin
            // Voided round: no credit, but the turn still passes on.
            timeout <= 1'b1;
            grant   <= 2'b00;
            ptr     <= grant[0] ? PLAYER1 : PLAYER0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SCORE: begin
          score0 <= new_score0;
          score1 <= new_score1;
          grant  <= 2'b00;
          ptr    <= grant[0] ? PLAYER1 : PLAYER0;
          if (ends_match) match_winner <= (new_score1 > new_score0);
        end
        ST_DONE: begin
          if (new_match) begin
            score0       <= '0;
            score1       <= '0;
            match_winner <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_turn_arbiter.sv
// Self-checking bench for game_turn_arbiter: directed rounds from the test
// plan followed by randomized rounds against a round-level reference model.
module tb_game_turn_arbiter;

  localparam int INPUT      = 4;
  localparam int TARGET     = 15;
  localparam int WIN_POINTS = 3;
  localparam int TIMEOUT    = 64;
  localparam int SW         = $clog2(WIN_POINTS + 1);

  localparam int O_WIN       = 0;
  localparam int O_LOSS      = 1;
  localparam int O_TMO       = 2;
  localparam int O_LOSS_OVER = 3;
  localparam int O_WIN_OVER  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       p0_mode, p1_mode;
  logic [INPUT-1:0] p0_seed, p1_seed;
  logic             new_match;
  logic [1:0]       grant;
  logic [1:0]       game_ctrl;
  logic [INPUT-1:0] game_seed;
  logic             game_init;
  logic             game_winner, game_loser, game_over;
  logic [SW-1:0]    score0, score1;
  logic             busy, timeout, match_done, match_winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept at the level of whole rounds.
  int sc[2];
  int ptr_m;
  bit done_m;
  int win_m;

  game_turn_arbiter #(
    .INPUT(INPUT), .TARGET(TARGET), .WIN_POINTS(WIN_POINTS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .p0_mode(p0_mode), .p1_mode(p1_mode), .p0_seed(p0_seed), .p1_seed(p1_seed),
    .new_match(new_match), .grant(grant), .game_ctrl(game_ctrl),
    .game_seed(game_seed), .game_init(game_init),
    .game_winner(game_winner), .game_loser(game_loser), .game_over(game_over),
    .score0(score0), .score1(score1), .busy(busy), .timeout(timeout),
    .match_done(match_done), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_m(input int s);
    if (s == 0) return 1;
    if (s >= TARGET) return TARGET - 1;
    return s;
  endfunction

  // One turn, starting and ending in IDLE one step after a rising edge.
  task automatic run_round(input logic [1:0] r, input int outcome, input int delay,
                           input logic [1:0] m0, input logic [1:0] m1,
                           input logic [3:0] s0, input logic [3:0] s1);
    int g;
    int n;
    bit is_win, is_over;
    p0_mode = m0; p1_mode = m1; p0_seed = s0; p1_seed = s1;
    req = r;
    if (r == 2'b00) begin
      tick();
      check("idle_grant", grant, 0);
      check("idle_busy", busy, 0);
      return;
    end
    g = (r == 2'b11) ? ptr_m : (r[1] ? 1 : 0);
    tick();
    req = 2'b00;
    check("grant", grant, 1 << g);
    check("game_ctrl", game_ctrl, (g == 1) ? m1 : m0);
    check("game_seed", game_seed, clamp_m((g == 1) ? int'(s1) : int'(s0)));
    check("init_high", game_init, 1);
    check("busy_load", busy, 1);
    tick();
    check("init_low", game_init, 0);
    if (outcome == O_TMO) begin
      n = 0;
      while (timeout !== 1'b1 && n < 3 * TIMEOUT) begin
        tick();
        n++;
      end
      check("timeout_latency", n, TIMEOUT + 1);
      check("tmo_score0", score0, sc[0]);
      check("tmo_score1", score1, sc[1]);
      check("tmo_grant", grant, 0);
      check("tmo_busy", busy, 0);
      tick();
      check("timeout_single", timeout, 0);
      ptr_m = 1 - g;
      return;
    end
    repeat (delay) tick();
    is_win  = (outcome == O_WIN) || (outcome == O_WIN_OVER);
    is_over = (outcome == O_LOSS_OVER) || (outcome == O_WIN_OVER);
    game_winner = is_win;
    game_loser  = !is_win;
    game_over   = is_over;
    tick();
    game_winner = 1'b0; game_loser = 1'b0; game_over = 1'b0;
    tick();
    if (is_win && sc[g] < WIN_POINTS) sc[g]++;
    done_m = (is_win && sc[g] == WIN_POINTS) || is_over;
    ptr_m  = 1 - g;
    if (done_m) win_m = (sc[1] > sc[0]) ? 1 : 0;
    check("score0", score0, sc[0]);
    check("score1", score1, sc[1]);
    check("grant_drop", grant, 0);
    check("busy_end", busy, 0);
    check("match_done", match_done, done_m);
    if (done_m) check("match_winner", match_winner, win_m);
  endtask

  // In DONE: requests are ignored, then new_match (with req) clears the match.
  task automatic finish_match(input logic [1:0] rq);
    req = rq;
    repeat (3) tick();
    check("done_ignores_req", grant, 0);
    check("done_busy", busy, 0);
    check("done_hold", match_done, 1);
    check("done_winner_hold", match_winner, win_m);
    new_match = 1'b1;
    tick();
    new_match = 1'b0;
    check("new_match_done", match_done, 0);
    check("new_match_s0", score0, 0);
    check("new_match_s1", score1, 0);
    check("new_match_grant", grant, 0);
    check("new_match_busy", busy, 0);
    sc[0] = 0; sc[1] = 0; done_m = 0;
  endtask

  initial begin
    int o, x, rr;
    sc[0] = 0; sc[1] = 0; ptr_m = 0; done_m = 0; win_m = 0;
    rst = 1'b0; req = 2'b00; new_match = 1'b0;
    p0_mode = '0; p1_mode = '0; p0_seed = '0; p1_seed = '0;
    game_winner = 1'b0; game_loser = 1'b0; game_over = 1'b0;

    #3;
    check("rst_grant", grant, 0);
    check("rst_init", game_init, 0);
    check("rst_busy", busy, 0);
    check("rst_done", match_done, 0);
    check("rst_seed", game_seed, 0);
    #9 rst = 1'b1;
    tick(); tick();
    check("post_rst_grant", grant, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_timeout", timeout, 0);
    check("post_rst_scores", {score1, score0}, 0);

    // Tie goes to player 0, then player 1; seed clamping at both ends.
    run_round(2'b11, O_WIN, 0, 2'b01, 2'b10, 4'd0, 4'd7);
    run_round(2'b11, O_WIN, 2, 2'b11, 2'b10, 4'd5, 4'd15);
    // Player 1 wins the match with player 0 losses in between.
    run_round(2'b01, O_LOSS, 1, 2'b00, 2'b01, 4'd3, 4'd2);
    run_round(2'b10, O_WIN, 0, 2'b00, 2'b01, 4'd3, 4'd9);
    run_round(2'b01, O_LOSS, 3, 2'b10, 2'b01, 4'd14, 4'd2);
    run_round(2'b10, O_WIN, 1, 2'b00, 2'b11, 4'd3, 4'd12);
    finish_match(2'b11);
    // Timeout with a tie pending: next tie must go to the other player.
    run_round(2'b11, O_TMO, 0, 2'b01, 2'b10, 4'd4, 4'd4);
    run_round(2'b11, O_LOSS, 0, 2'b01, 2'b10, 4'd4, 4'd6);

    // Bring player 0 to 2 points, then reset in the middle of WAIT.
    run_round(2'b01, O_WIN, 0, 2'b01, 2'b00, 4'd8, 4'd1);
    run_round(2'b01, O_WIN, 0, 2'b01, 2'b00, 4'd8, 4'd1);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_score0", score0, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_init", game_init, 0);
    check("mid_rst_busy", busy, 0);
    #2 rst = 1'b1;
    tick();
    sc[0] = 0; sc[1] = 0; ptr_m = 0; done_m = 0;

    // game_over at 1-1: tie goes to player 0.
    run_round(2'b01, O_WIN, 0, 2'b00, 2'b00, 4'd2, 4'd2);
    run_round(2'b10, O_WIN, 0, 2'b00, 2'b00, 4'd2, 4'd2);
    run_round(2'b01, O_LOSS_OVER, 2, 2'b00, 2'b00, 4'd2, 4'd2);
    finish_match(2'b10);
    rr = 2'b10;

    for (int i = 0; i < 40; i++) begin
      if (i > 0) rr = $urandom_range(0, 3);
      x = $urandom_range(0, 19);
      if (x == 0)       o = O_TMO;
      else if (x < 10)  o = O_WIN;
      else if (x < 17)  o = O_LOSS;
      else if (x == 17) o = O_LOSS_OVER;
      else              o = O_WIN_OVER;
      run_round(2'(rr), o, $urandom_range(0, 6),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (done_m) finish_match(2'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
